led_phase_monitor: RTL

//  Passive checker on the far end of the traffic-light LED lines. Samples red/green/blue,

---
 rtl/led_phase_monitor.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/led_phase_monitor.sv
// Passive monitor for the RED->GREEN->BLUE->OFF LED sequence: checks order, overlap and dwell.
// Define LED_MON_SYNC_EN to put a 2-flop synchronizer on each LED line ahead of the sample stage.
module led_phase_monitor #(
  parameter int unsigned RED_CYCLES   = 100_000_000,
  parameter int unsigned GREEN_CYCLES = 50_000_000,
  parameter int unsigned BLUE_CYCLES  = 20_000_000,
  parameter int unsigned OFF_CYCLES   = 1,
  parameter int unsigned TOL_CYCLES   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        red_led,
  input  logic        green_led,
  input  logic        blue_led,
  input  logic        err_clr,
  output logic        locked,
  output logic [1:0]  phase,
  output logic        phase_err,
  output logic [2:0]  err_code,
  output logic        err_flag,
  output logic [15:0] cycle_count
);

  typedef enum logic [2:0] {ST_UNSYNC, ST_RED, ST_GREEN, ST_BLUE, ST_OFF} state_t;

`ifdef LED_MON_SYNC_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 1;
`endif

  // Last pipeline stage is the sample register; earlier stages (if any) are synchronizer flops.
  logic [2:0] led_pipe_reg [DEPTH];
  logic       vld_pipe_reg [DEPTH];
  logic [2:0] led_in;
  logic [2:0] samp;
  logic       samp_vld;

  state_t      state_reg, state_next, samp_state, succ_state;
  logic [31:0] dwell_reg, dwell_next;
  logic [32:0] exp_cur, dwell_hi, dwell_lo;
  logic        prev_nonred_reg;
  logic        locked_reg;
  logic [1:0]  phase_reg, phase_next;
  logic        phase_err_reg, err_next;
  logic [2:0]  err_code_reg, code_next;
  logic        err_flag_reg;
  logic [15:0] cycle_count_reg, count_next;

  assign led_in   = {blue_led, green_led, red_led};
  assign samp     = led_pipe_reg[DEPTH-1];
  assign samp_vld = vld_pipe_reg[DEPTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        led_pipe_reg[i] <= '0;
        vld_pipe_reg[i] <= 1'b0;
      end
    end else begin
      led_pipe_reg[0] <= led_in;
      vld_pipe_reg[0] <= 1'b1;
      for (int i = 1; i < DEPTH; i++) begin
        led_pipe_reg[i] <= led_pipe_reg[i-1];
        vld_pipe_reg[i] <= vld_pipe_reg[i-1];
      end
    end
  end

  always_comb begin
    samp_state = ST_OFF;
    case (samp)
      3'b001:  samp_state = ST_RED;
      3'b010:  samp_state = ST_GREEN;
      3'b100:  samp_state = ST_BLUE;
      default: samp_state = ST_OFF;
    endcase
    succ_state = ST_RED;
    exp_cur    = 33'(OFF_CYCLES);
    case (state_reg)
      ST_RED:   begin succ_state = ST_GREEN; exp_cur = 33'(RED_CYCLES);   end
      ST_GREEN: begin succ_state = ST_BLUE;  exp_cur = 33'(GREEN_CYCLES); end
      ST_BLUE:  begin succ_state = ST_OFF;   exp_cur = 33'(BLUE_CYCLES);  end
      default:  begin succ_state = ST_RED;   exp_cur = 33'(OFF_CYCLES);   end
    endcase
    dwell_hi = exp_cur + 33'(TOL_CYCLES);
    dwell_lo = (exp_cur > 33'(TOL_CYCLES)) ? exp_cur - 33'(TOL_CYCLES) : 33'd0;
  end

  always_comb begin
    state_next = state_reg;
    dwell_next = dwell_reg;
    code_next  = 3'd0;
    count_next = cycle_count_reg;
    if (samp_vld) begin
      if (state_reg == ST_UNSYNC) begin
        // Only a fresh red edge is trusted, so a partial red after reset is never measured.
        if (samp == 3'b001 && prev_nonred_reg) begin
          state_next = ST_RED;
          dwell_next = 32'd1;
        end
      end else if ($countones(samp) > 1) begin
        code_next = 3'd1;
      end else if (samp_state == state_reg) begin
        if ({1'b0, dwell_reg} >= dwell_hi)
          code_next = 3'd4;
        else if (dwell_reg != '1)
          dwell_next = dwell_reg + 32'd1;
      end else if (samp_state == succ_state) begin
        if ({1'b0, dwell_reg} < dwell_lo) begin
          code_next = 3'd3;
        end else begin
          state_next = samp_state;
          dwell_next = 32'd1;
          if (state_reg == ST_OFF && cycle_count_reg != 16'hFFFF)
            count_next = cycle_count_reg + 16'd1;
        end
      end else begin
        code_next = 3'd2;
      end
    end
    err_next = (code_next != 3'd0);
    if (err_next) begin
      state_next = ST_UNSYNC;
      dwell_next = 32'd0;
    end
    case (state_next)
      ST_RED:   phase_next = 2'd1;
      ST_GREEN: phase_next = 2'd2;
      ST_BLUE:  phase_next = 2'd3;
      default:  phase_next = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_UNSYNC;
      dwell_reg       <= '0;
      prev_nonred_reg <= 1'b0;
      locked_reg      <= 1'b0;
      phase_reg       <= 2'd0;
      phase_err_reg   <= 1'b0;
      err_code_reg    <= 3'd0;
      err_flag_reg    <= 1'b0;
      cycle_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      dwell_reg       <= dwell_next;
      prev_nonred_reg <= samp_vld && !samp[0];
      locked_reg      <= (state_next != ST_UNSYNC);
      phase_reg       <= phase_next;
      phase_err_reg   <= err_next;
      cycle_count_reg <= count_next;
      // A new error outranks a simultaneous clear.
      if (err_next) begin
        err_code_reg <= code_next;
        err_flag_reg <= 1'b1;
      end else if (err_clr) begin
        err_code_reg <= 3'd0;
        err_flag_reg <= 1'b0;
      end
    end
  end

  assign locked      = locked_reg;
  assign phase       = phase_reg;
  assign phase_err   = phase_err_reg;
  assign err_code    = err_code_reg;
  assign err_flag    = err_flag_reg;
  assign cycle_count = cycle_count_reg;

endmodule
